// File: rtl/arb_mux2x1.sv
// Two-source round-robin arbiter feeding a single registered output stage.
// Tracks accepted-word counts per source; ties alternate starting with A.
module arb_mux2x1 #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_a_valid,
  input  logic [DATA_WIDTH-1:0] in_a_data,
  output logic                  in_a_ready,
  input  logic                  in_b_valid,
  input  logic [DATA_WIDTH-1:0] in_b_data,
  output logic                  in_b_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sel,
  output logic [CNT_WIDTH-1:0]  cnt_a,
  output logic [CNT_WIDTH-1:0]  cnt_b
);

  logic last_grant;
  logic can_load;
  logic grant_a;
  logic grant_b;
  logic acc_a;
  logic acc_b;

  assign can_load = !out_valid | out_ready;

  // last_grant=1 means B won last, so a tie goes to A
  assign grant_a = in_a_valid & (!in_b_valid | last_grant);
  assign grant_b = in_b_valid & (!in_a_valid | !last_grant);

  assign in_a_ready = grant_a & can_load & !reset;
  assign in_b_ready = grant_b & can_load & !reset;

  assign acc_a = in_a_valid & in_a_ready;
  assign acc_b = in_b_valid & in_b_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= 1'b0;
      last_grant <= 1'b1;
      cnt_a      <= '0;
      cnt_b      <= '0;
    end else begin
      if (acc_a | acc_b) begin
        out_valid  <= 1'b1;
        out_data   <= acc_b ? in_b_data : in_a_data;
        out_sel    <= acc_b;
        last_grant <= acc_b;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (acc_a)
        cnt_a <= cnt_a + CNT_WIDTH'(1);
      if (acc_b)
        cnt_b <= cnt_b + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_arb_mux2x1.sv
// Directed and randomized checks for arb_mux2x1.
// Counter width is reduced so the wrap case stays short.
module tb_arb_mux2x1;

  localparam int DW = 8;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_a_valid = 1'b0;
  logic [DW-1:0] in_a_data = '0;
  logic          in_a_ready;
  logic          in_b_valid = 1'b0;
  logic [DW-1:0] in_b_data = '0;
  logic          in_b_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_sel;
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;

  int tests = 0;
  int fails = 0;

  arb_mux2x1 #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_a_valid (in_a_valid),
    .in_a_data  (in_a_data),
    .in_a_ready (in_a_ready),
    .in_b_valid (in_b_valid),
    .in_b_data  (in_b_data),
    .in_b_ready (in_b_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sel    (out_sel),
    .cnt_a      (cnt_a),
    .cnt_b      (cnt_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_a_valid = 1'b0;
    in_b_valid = 1'b0;
    out_ready  = 1'b0;
    #2;
    reset = 1'b1;
    tick();
    #2;
    reset = 1'b0;
    #1;
  endtask

  logic [8:0] q[$];
  logic [8:0] fr;
  logic       m_ov, m_lg, m_can, ga, gb, era, erb;
  logic       hold_a, hold_b;
  int         wait_a, wait_b;

  initial begin
    // reset state
    #3;
    chk("rst_ov", out_valid, 0);
    chk("rst_od", out_data, 0);
    chk("rst_ca", cnt_a, 0);
    chk("rst_cb", cnt_b, 0);
    chk("rst_ra", in_a_ready, 0);
    tick();
    #2;
    reset = 1'b0;

    // both valid, alternate starting with A
    in_a_valid = 1'b1; in_a_data = 8'h11;
    in_b_valid = 1'b1; in_b_data = 8'h22;
    out_ready  = 1'b1;
    #1;
    chk("alt_ra0", in_a_ready, 1);
    chk("alt_rb0", in_b_ready, 0);
    tick();
    chk("alt_d0", out_data, 8'h11);
    chk("alt_s0", out_sel, 0);
    chk("alt_v0", out_valid, 1);
    tick();
    chk("alt_d1", out_data, 8'h22);
    chk("alt_s1", out_sel, 1);
    tick();
    chk("alt_d2", out_data, 8'h11);
    chk("alt_s2", out_sel, 0);
    tick();
    chk("alt_d3", out_data, 8'h22);
    chk("alt_s3", out_sel, 1);
    chk("alt_ca", cnt_a, 2);
    chk("alt_cb", cnt_b, 2);

    // A only
    do_reset();
    in_a_valid = 1'b1; in_a_data = 8'h5A;
    out_ready  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("aonly_rb", in_b_ready, 0);
      tick();
      chk("aonly_d", out_data, 8'h5A);
      chk("aonly_s", out_sel, 0);
    end
    chk("aonly_ca", cnt_a, 3);
    chk("aonly_cb", cnt_b, 0);

    // backpressure
    do_reset();
    in_a_valid = 1'b1; in_a_data = 8'hAB;
    tick();
    chk("bp_v", out_valid, 1);
    chk("bp_d0", out_data, 8'hAB);
    in_a_data  = 8'h11;
    in_b_valid = 1'b1; in_b_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_ra", in_a_ready, 0);
      chk("bp_rb", in_b_ready, 0);
      tick();
      chk("bp_d", out_data, 8'hAB);
      chk("bp_v", out_valid, 1);
      chk("bp_ca", cnt_a, 1);
      chk("bp_cb", cnt_b, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rb_rel", in_b_ready, 1);
    tick();
    chk("bp_d_new", out_data, 8'h22);
    chk("bp_s_new", out_sel, 1);
    chk("bp_cb_new", cnt_b, 1);
    in_a_valid = 1'b0;
    in_b_valid = 1'b0;
    tick();
    chk("bp_drain", out_valid, 0);
    chk("bp_hold", out_data, 8'h22);

    // counter wrap
    do_reset();
    in_a_valid = 1'b1; in_a_data = 8'h33;
    out_ready  = 1'b1;
    for (int i = 0; i < (1 << CW) - 1; i++)
      tick();
    chk("wrap_pre", cnt_a, (1 << CW) - 1);
    tick();
    chk("wrap_zero", cnt_a, 0);

    // async reset mid-cycle with a word held
    chk("ar_v_pre", out_valid, 1);
    #3;
    reset = 1'b1;
    #1;
    chk("ar_ov", out_valid, 0);
    chk("ar_od", out_data, 0);
    chk("ar_ca", cnt_a, 0);
    chk("ar_ra", in_a_ready, 0);
    chk("ar_rb", in_b_ready, 0);
    tick();
    #2;
    in_b_valid = 1'b1; in_b_data = 8'h77;
    in_a_data  = 8'h66;
    reset = 1'b0;
    #1;
    chk("ar_first_a", in_a_ready, 1);
    tick();
    chk("ar_sel", out_sel, 0);
    chk("ar_data", out_data, 8'h66);

    // randomized with scoreboard
    do_reset();
    m_ov = 1'b0; m_lg = 1'b1;
    hold_a = 1'b0; hold_b = 1'b0;
    wait_a = 0; wait_b = 0;
    q.delete();
    for (int i = 0; i < 1000; i++) begin
      if (!hold_a) begin
        in_a_valid = 1'($urandom_range(0, 1));
        in_a_data  = 8'($urandom);
      end
      if (!hold_b) begin
        in_b_valid = 1'($urandom_range(0, 1));
        in_b_data  = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      m_can = !m_ov | out_ready;
      ga  = in_a_valid & (!in_b_valid | m_lg);
      gb  = in_b_valid & (!in_a_valid | !m_lg);
      era = ga & m_can;
      erb = gb & m_can;
      chk("rnd_ov", out_valid, m_ov);
      chk("rnd_ra", in_a_ready, era);
      chk("rnd_rb", in_b_ready, erb);
      if (m_ov && out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_q_empty", 1, 0);
        end else begin
          fr = q.pop_front();
          chk("rnd_d", out_data, fr[7:0]);
          chk("rnd_s", out_sel, fr[8]);
        end
      end
      if (era) wait_a = 0;
      else if (erb && in_a_valid) begin
        wait_a++;
        chk("rnd_fair_a", wait_a <= 1, 1);
      end
      if (erb) wait_b = 0;
      else if (era && in_b_valid) begin
        wait_b++;
        chk("rnd_fair_b", wait_b <= 1, 1);
      end
      if (era) q.push_back({1'b0, in_a_data});
      if (erb) q.push_back({1'b1, in_b_data});
      if (era | erb) begin
        m_ov = 1'b1;
        m_lg = erb;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      hold_a = in_a_valid & !era;
      hold_b = in_b_valid & !erb;
      tick();
    end
    in_a_valid = 1'b0;
    in_b_valid = 1'b0;
    out_ready  = 1'b1;
    #1;
    if (m_ov) begin
      fr = q.pop_front();
      chk("rnd_last_d", out_data, fr[7:0]);
      chk("rnd_last_s", out_sel, fr[8]);
    end
    tick();
    chk("rnd_empty", out_valid, 0);
    chk("rnd_q_left", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
